// File: rtl/accum_frame_driver.sv
// accum_frame_driver: frames a valid/ready complex stream into contiguous
// accumulator bursts (zero-filled bubbles, zero-padded to MIN_LEN, forced
// idle gap) and returns each accumulator sum through a small result FIFO.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_data/valid/last  input element stream; in_ready accepts it
//   acc_data/start/stop registered burst towards the accumulator
//   acc_out/_valid      accumulator sum; the sum follows its valid by 1 cycle
//   res_data/valid      head of result FIFO; res_ready pops it
//   err_overflow        sticky, a capture hit a full result FIFO
// Optional: define ACC_DRV_STATS_EN to add stat_frames, stat_bubbles and
// stat_pads (16-bit wrapping event counters).

package accum_frame_pkg;
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_t;
endpackage

module accum_frame_driver
    import accum_frame_pkg::*;
#(
    parameter int MIN_LEN      = 11,
    parameter int GAP_CYCLES   = 4,
    parameter int RES_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 64
) (
    input  logic     clk,
    input  logic     reset,
    input  complex_t in_data,
    input  logic     in_valid,
    input  logic     in_last,
    output logic     in_ready,
    output complex_t acc_data,
    output logic     acc_start,
    output logic     acc_stop,
    input  complex_t acc_out,
    input  logic     acc_out_valid,
    output complex_t res_data,
    output logic     res_valid,
    input  logic     res_ready,
    output logic     err_overflow
`ifdef ACC_DRV_STATS_EN
    ,
    output logic [15:0] stat_frames,
    output logic [15:0] stat_bubbles,
    output logic [15:0] stat_pads
`endif
);

    localparam int CW = $clog2(MIN_LEN + 2);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam int FW = $clog2(FLUSH_CYCLES + 2);
    localparam int OW = $clog2(RES_DEPTH + 2);
    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

    localparam logic [CW-1:0] MIN_C = CW'(MIN_LEN);
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [FW-1:0] FLUSH_C = FW'(FLUSH_CYCLES);
    localparam logic [OW:0]   DEPTH_C = (OW + 1)'(RES_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAD,
        GAP
    } state_t;

    localparam state_t AFTER_STOP = (GAP_CYCLES > 0) ? GAP : IDLE;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n, cnt_inc;
    logic [GW-1:0]   gap_cnt, gap_n;
    complex_t        data_n;
    logic            start_n, stop_n;
    logic            bubble_ev, pad_ev;

    logic [FW-1:0]   flush_cnt;
    logic            flushing;
    logic            cap_pend;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   fifo_count;
    logic            credit_ok;

    complex_t        mem [RES_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            fifo_full, pop, do_push;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(RES_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign flushing  = (flush_cnt != FLUSH_C);
    // Frames in flight plus unread results may never exceed the FIFO size,
    // so a correctly behaving accumulator can never overflow it.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C;
    assign cnt_inc   = (cnt >= MIN_C) ? cnt : cnt + CW'(1);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        gap_n     = gap_cnt;
        data_n    = '0;
        start_n   = 1'b0;
        stop_n    = 1'b0;
        in_ready  = 1'b0;
        bubble_ev = 1'b0;
        pad_ev    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = credit_ok && !flushing;
                if (in_valid && in_ready) begin
                    start_n = 1'b1;
                    data_n  = in_data;
                    cnt_n   = CW'(1);
                    if (in_last) begin
                        if (MIN_LEN <= 1) begin
                            stop_n  = 1'b1;
                            state_n = AFTER_STOP;
                            gap_n   = '0;
                        end else begin
                            state_n = PAD;
                        end
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN: begin
                in_ready = 1'b1;
                cnt_n    = cnt_inc;
                if (in_valid) begin
                    data_n = in_data;
                end else begin
                    bubble_ev = 1'b1;
                end
                if (in_valid && in_last) begin
                    if (cnt_inc >= MIN_C) begin
                        stop_n  = 1'b1;
                        state_n = AFTER_STOP;
                        gap_n   = '0;
                    end else begin
                        state_n = PAD;
                    end
                end
            end
            PAD: begin
                pad_ev = 1'b1;
                cnt_n  = cnt_inc;
                if (cnt_inc >= MIN_C) begin
                    stop_n  = 1'b1;
                    state_n = AFTER_STOP;
                    gap_n   = '0;
                end
            end
            GAP: begin
                if (gap_cnt >= GAP_LAST) begin
                    state_n = IDLE;
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            gap_cnt   <= '0;
            acc_data  <= '0;
            acc_start <= 1'b0;
            acc_stop  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            gap_cnt   <= gap_n;
            acc_data  <= data_n;
            acc_start <= start_n;
            acc_stop  <= stop_n;
        end
    end

    // The accumulator may emit garbage valids while its pipeline drains
    // after reset; those are ignored and no new frame starts meanwhile.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt <= '0;
            cap_pend  <= 1'b0;
        end else begin
            if (flushing) begin
                flush_cnt <= flush_cnt + FW'(1);
            end
            cap_pend <= acc_out_valid && !flushing;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else if (acc_stop && !cap_pend) begin
            outstanding <= outstanding + OW'(1);
        end else if (!acc_stop && cap_pend && outstanding != '0) begin
            outstanding <= outstanding - OW'(1);
        end
    end

    assign fifo_full = (fifo_count == OW'(RES_DEPTH));
    assign res_valid = (fifo_count != '0);
    assign pop       = res_valid && res_ready;
    // Simultaneous pop frees the slot, so a push into a full FIFO is legal.
    assign do_push   = cap_pend && (!fifo_full || pop);
    assign res_data  = res_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= acc_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            err_overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (do_push && !pop) begin
                fifo_count <= fifo_count + OW'(1);
            end else if (!do_push && pop) begin
                fifo_count <= fifo_count - OW'(1);
            end
            if (cap_pend && !do_push) begin
                err_overflow <= 1'b1;
            end
        end
    end

`ifdef ACC_DRV_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_frames  <= '0;
            stat_bubbles <= '0;
            stat_pads    <= '0;
        end else begin
            if (acc_stop) begin
                stat_frames <= stat_frames + 16'd1;
            end
            if (bubble_ev) begin
                stat_bubbles <= stat_bubbles + 16'd1;
            end
            if (pad_ev) begin
                stat_pads <= stat_pads + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_accum_frame_driver.sv
// tb_accum_frame_driver: self-checking bench for accum_frame_driver with a
// behavioural accumulator, a frame-level reference model and scoreboards.

module tb_accum_frame_driver;
    import accum_frame_pkg::*;

    localparam int MIN_LEN = 11;
    localparam int GAP     = 4;
    localparam int FLUSH   = 64;
    localparam int LAT     = 5;

    logic     clk = 1'b0;
    logic     reset;
    complex_t in_data;
    logic     in_valid, in_last, in_ready;
    complex_t acc_data;
    logic     acc_start, acc_stop;
    complex_t acc_out;
    logic     acc_out_valid;
    complex_t res_data;
    logic     res_valid, res_ready, err_overflow;
`ifdef ACC_DRV_STATS_EN
    logic [15:0] stat_frames, stat_bubbles, stat_pads;
`endif

    accum_frame_driver dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .acc_data      (acc_data),
        .acc_start     (acc_start),
        .acc_stop      (acc_stop),
        .acc_out       (acc_out),
        .acc_out_valid (acc_out_valid),
        .res_data      (res_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .err_overflow  (err_overflow)
`ifdef ACC_DRV_STATS_EN
        ,
        .stat_frames   (stat_frames),
        .stat_bubbles  (stat_bubbles),
        .stat_pads     (stat_pads)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    complex_t exp_q[$];
    int       len_q[$];
    complex_t fr_data[$];
    int       fr_bub[$];
    int       rr_mode;
    int       bursts = 0;
    int       last_gap = -1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    function automatic complex_t cadd(input complex_t a, input complex_t b);
        complex_t r;
        r.re = a.re + b.re;
        r.im = a.im + b.im;
        return r;
    endfunction

    function automatic complex_t cval(input int re, input int im);
        complex_t r;
        r.re = 16'(re);
        r.im = 16'(im);
        return r;
    endfunction

    // Behavioural accumulator: sums a burst, signals LAT cycles after stop,
    // sum follows one cycle later; other cycles drive noise on acc_out.
    logic     model_valid, manual_valid;
    logic     in_acc;
    complex_t sum_r, hold, nsum;
    logic [LAT-1:0] pv;
    complex_t ps [LAT];

    assign acc_out_valid = model_valid | manual_valid;
    assign nsum = acc_start ? acc_data : cadd(sum_r, acc_data);

    always @(posedge clk) begin
        if (reset) begin
            pv          <= '0;
            in_acc      <= 1'b0;
            model_valid <= 1'b0;
            sum_r       <= '0;
            acc_out     <= '0;
        end else begin
            if (acc_start || in_acc) sum_r <= nsum;
            in_acc <= (acc_start || in_acc) && !acc_stop;
            pv     <= {pv[LAT-2:0], acc_stop};
            ps[0]  <= nsum;
            for (int i = 1; i < LAT; i++) ps[i] <= ps[i-1];
            model_valid <= pv[LAT-1];
            hold        <= ps[LAT-1];
            acc_out     <= model_valid ? hold : complex_t'($urandom);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_mode == 0) res_ready = 1'b0;
            else if (rr_mode == 1) res_ready = 1'b1;
            else res_ready = 1'($urandom_range(0, 1));
        end
    end

    // Result scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(res_data), 64'hdead);
                end else begin
                    check("res_data", 64'(res_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // Burst-shape monitor.
    initial begin
        bit in_b = 0;
        bit have_stop = 0;
        int blen = 0;
        int gap = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_b = 0;
                have_stop = 0;
            end else begin
                if (acc_start) begin
                    check("start_in_burst", 64'(in_b), 64'(0));
                    check("start_and_stop", 64'(acc_stop), 64'(0));
                    if (have_stop) begin
                        check("gap_min", 64'(gap >= GAP), 64'(1));
                        last_gap = gap;
                    end
                    in_b = 1;
                    blen = 0;
                end
                if (in_b) begin
                    blen++;
                    if (acc_stop) begin
                        if (len_q.size() == 0)
                            check("unexpected_stop", 64'(blen), 64'(0));
                        else
                            check("burst_len", 64'(blen), 64'(len_q.pop_front()));
                        in_b = 0;
                        have_stop = 1;
                        gap = 0;
                        bursts++;
                    end
                end else begin
                    if (acc_stop || acc_data != '0)
                        check("idle_drive", {31'd0, acc_stop, acc_data}, 64'(0));
                    if (have_stop) gap++;
                end
            end
        end
    end

    task automatic send_frame(input int budget);
        int n = fr_data.size();
        int i = 0;
        int bub = 0;
        int waited = 0;
        bit acc;
        complex_t s = '0;
        while (i < n) begin
            in_valid = 1'b1;
            in_data  = fr_data[i];
            in_last  = (i == n - 1);
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                s = cadd(s, fr_data[i]);
                if (i == n - 1) begin
                    exp_q.push_back(s);
                    len_q.push_back((n + bub > MIN_LEN) ? n + bub : MIN_LEN);
                end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                if (i < n) begin
                    for (int k = 0; k < fr_bub[i-1]; k++) begin
                        in_valid = 1'b0;
                        in_data  = complex_t'($urandom);
                        in_last  = 1'($urandom_range(0, 1));
                        bub++;
                        @(posedge clk);
                        #1;
                    end
                end
            end else begin
                waited++;
                if (waited > budget) begin
                    check("accept_timeout", 64'(waited), 64'(budget));
                    break;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic fill(input int n, input complex_t v, input bit rnd,
                        input int bub_pct);
        fr_data.delete();
        fr_bub.delete();
        for (int i = 0; i < n; i++) begin
            fr_data.push_back(rnd ? cval(int'($urandom_range(0, 200)) - 100,
                                         int'($urandom_range(0, 200)) - 100)
                                  : v);
            fr_bub.push_back(($urandom_range(0, 99) < bub_pct)
                             ? int'($urandom_range(1, 3)) : 0);
        end
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && c < 3000) begin
            @(posedge clk);
            c++;
        end
        check("drain_timeout", 64'(exp_q.size() + len_q.size()), 64'(0));
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int b0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        manual_valid = 1'b0;
        rr_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start", 64'(acc_start), 64'(0));
        check("rst_stop", 64'(acc_stop), 64'(0));
        check("rst_data", 64'(acc_data), 64'(0));
        check("rst_res_valid", 64'(res_valid), 64'(0));
        check("rst_res_data", 64'(res_data), 64'(0));
        check("rst_overflow", 64'(err_overflow), 64'(0));
        reset = 1'b0;
        in_valid = 1'b1;
        in_data = cval(7, 7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        repeat (FLUSH) @(posedge clk);
        @(negedge clk);
        check("post_flush_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        fill(16, cval(1, 2), 0, 0);
        send_frame(200);
        wait_drain();

        fill(5, cval(3, -1), 0, 0);
        send_frame(200);
        wait_drain();

        fill(12, cval(1, 1), 0, 0);
        fr_bub[5] = 3;
        send_frame(200);
        wait_drain();
`ifdef ACC_DRV_STATS_EN
        check("stat_frames", 64'(stat_frames), 64'(3));
        check("stat_pads", 64'(stat_pads), 64'(6));
        check("stat_bubbles", 64'(stat_bubbles), 64'(3));
`endif

        fill(12, cval(2, 0), 0, 0);
        send_frame(200);
        fill(12, cval(0, 2), 0, 0);
        send_frame(200);
        wait_drain();
        check("gap_b2b", 64'(last_gap), 64'(GAP));

        rr_mode = 0;
        b0 = bursts;
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    fill(12, '0, 1, 0);
                    send_frame(3000);
                end
            end
            begin
                repeat (400) @(posedge clk);
                @(negedge clk);
                check("credit_bursts", 64'(bursts - b0), 64'(4));
                check("credit_in_ready", 64'(in_ready), 64'(0));
                check("full_res_valid", 64'(res_valid), 64'(1));
                rr_mode = 1;
            end
        join
        wait_drain();
        check("credit_total", 64'(bursts - b0), 64'(6));
        check("no_overflow", 64'(err_overflow), 64'(0));

        rr_mode = 2;
        for (int f = 0; f < 30; f++) begin
            fill(int'($urandom_range(1, 20)), '0, 1, 25);
            send_frame(3000);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_drain();
        check("rand_overflow", 64'(err_overflow), 64'(0));

        rr_mode = 1;
        fill(20, cval(5, 5), 0, 0);
        fork
            send_frame(200);
            begin
                repeat (8) @(posedge clk);
                #1;
                reset = 1'b1;
            end
        join_any
        disable fork;
        in_valid = 1'b0;
        exp_q.delete();
        len_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        manual_valid = 1'b1;
        @(posedge clk);
        #1;
        manual_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_mid_res_valid", 64'(res_valid), 64'(0));
        check("rst_mid_in_ready", 64'(in_ready), 64'(0));
        check("rst_mid_acc", {31'd0, acc_start, acc_data}, 64'(0));
        repeat (FLUSH) @(posedge clk);
        @(negedge clk);
        check("rst_mid_idle", 64'(in_ready), 64'(1));
        check("rst_mid_res_still0", 64'(res_valid), 64'(0));
        @(posedge clk);
        #1;
        fill(11, '0, 1, 0);
        send_frame(200);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
